// File: rtl/ssd1306_spi_rx_if.sv
// SSD1306 4-wire SPI receive link bundle: raw link pins driven by the display
// master plus the decoded byte/pixel/status outputs of the receiver.
// Optional macro LCD_RX_CMD_COUNT_EN adds the o_cmd_count status output.
interface ssd1306_spi_rx_if;
    logic       i_spi_rst_n;
    logic       i_cs_n;
    logic       i_dc;
    logic       i_sclk;
    logic       i_mosi;
    logic       o_byte_valid;
    logic [7:0] o_byte;
    logic       o_byte_dc;
    logic       o_pix_we;
    logic [6:0] o_pix_col;
    logic [2:0] o_pix_page;
    logic [7:0] o_pix_data;
    logic       o_disp_on;
    logic [7:0] o_contrast;
    logic [1:0] o_addr_mode;
    logic       o_frame_err;
`ifdef LCD_RX_CMD_COUNT_EN
    logic [15:0] o_cmd_count;

    modport master (
        output i_spi_rst_n, i_cs_n, i_dc, i_sclk, i_mosi,
        input  o_byte_valid, o_byte, o_byte_dc, o_pix_we, o_pix_col, o_pix_page,
        input  o_pix_data, o_disp_on, o_contrast, o_addr_mode, o_frame_err, o_cmd_count
    );
    modport slave (
        input  i_spi_rst_n, i_cs_n, i_dc, i_sclk, i_mosi,
        output o_byte_valid, o_byte, o_byte_dc, o_pix_we, o_pix_col, o_pix_page,
        output o_pix_data, o_disp_on, o_contrast, o_addr_mode, o_frame_err, o_cmd_count
    );
`else
    modport master (
        output i_spi_rst_n, i_cs_n, i_dc, i_sclk, i_mosi,
        input  o_byte_valid, o_byte, o_byte_dc, o_pix_we, o_pix_col, o_pix_page,
        input  o_pix_data, o_disp_on, o_contrast, o_addr_mode, o_frame_err
    );
    modport slave (
        input  i_spi_rst_n, i_cs_n, i_dc, i_sclk, i_mosi,
        output o_byte_valid, o_byte, o_byte_dc, o_pix_we, o_pix_col, o_pix_page,
        output o_pix_data, o_disp_on, o_contrast, o_addr_mode, o_frame_err
    );
`endif
endinterface

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 SPI receiver: synchronises the mode-0 link into i_clk, deserialises
// MSB-first bytes, decodes the command subset and emits pixel-column writes.
// Optional macro LCD_RX_CMD_COUNT_EN adds a saturating command-byte counter.
module ssd1306_spi_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COLS        = 128,
    parameter int unsigned PAGES       = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    ssd1306_spi_rx_if.slave  bus
);
    localparam logic [6:0] ColLast  = 7'(COLS - 1);
    localparam logic [2:0] PageLast = 3'(PAGES - 1);

    typedef enum logic [0:0] {DecCmd, DecArg} dec_state_e;
    typedef enum logic [1:0] {OpNone, OpContrast, OpMode} arg_op_e;

    logic [SYNC_STAGES-1:0] rstn_sync_q, cs_sync_q, dc_sync_q, sclk_sync_q, mosi_sync_q;
    logic rstn_s, cs_s, dc_s, sclk_s, mosi_s, srst;

    assign rstn_s = rstn_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    // Link reset behaves exactly like the system reset while held low.
    assign srst   = i_rst | ~rstn_s;

    // Input synchronisers; only the system reset clears them so the link
    // reset synchroniser cannot hold itself in reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rstn_sync_q <= '1;
            cs_sync_q   <= '1;
            dc_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
        end else begin
            rstn_sync_q <= {rstn_sync_q[SYNC_STAGES-2:0], bus.i_spi_rst_n};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.i_cs_n};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], bus.i_dc};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.i_mosi};
        end
    end

    logic sclk_prev_q, cs_prev_q, rise_q, cs_rise_q, cs_hi_q, mosi_q, dc_q;

    // Edge detection stage; an SCLK rise coinciding with CS high is dropped.
    always_ff @(posedge i_clk) begin
        if (srst) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            rise_q      <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_hi_q     <= 1'b1;
            mosi_q      <= 1'b0;
            dc_q        <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            rise_q      <= sclk_s & ~sclk_prev_q & ~cs_s;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            cs_hi_q     <= cs_s;
            mosi_q      <= mosi_s;
            dc_q        <= dc_s;
        end
    end

    logic [7:0] shift_q, shift_d, byte_q, byte_d;
    logic [2:0] cnt_q, cnt_d;
    logic       byte_valid_q, byte_valid_d, byte_dc_q, byte_dc_d, frame_err_q, frame_err_d;

    // Deserialiser next state: shift on each rise, emit on the 8th.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        byte_dc_d    = byte_dc_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (cs_hi_q) begin
            cnt_d       = 3'd0;
            frame_err_d = cs_rise_q & (cnt_q != 3'd0);
        end else if (rise_q) begin
            shift_d = {shift_q[6:0], mosi_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_d       = shift_d;
                byte_dc_d    = dc_q;
            end
        end
    end

    // Deserialiser state register.
    always_ff @(posedge i_clk) begin
        if (srst) begin
            shift_q      <= 8'h00;
            cnt_q        <= 3'd0;
            byte_q       <= 8'h00;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            byte_dc_q    <= byte_dc_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    dec_state_e state_q, state_d;
    arg_op_e    arg_op_q, arg_op_d;
    logic       disp_on_q, disp_on_d;
    logic [7:0] contrast_q, contrast_d;
    logic [1:0] mode_q, mode_d;
    logic [6:0] col_q, col_d;
    logic [2:0] page_q, page_d;

    // Decoder: acts on the byte during its o_byte_valid cycle.
    always_comb begin
        state_d    = state_q;
        arg_op_d   = arg_op_q;
        disp_on_d  = disp_on_q;
        contrast_d = contrast_q;
        mode_d     = mode_q;
        col_d      = col_q;
        page_d     = page_q;
        if (byte_valid_q) begin
            if (byte_dc_q) begin
                // Data also aborts any pending argument.
                state_d  = DecCmd;
                arg_op_d = OpNone;
                case (mode_q)
                    2'b00: begin
                        if (col_q == ColLast) begin
                            col_d  = 7'd0;
                            page_d = (page_q == PageLast) ? 3'd0 : page_q + 3'd1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end
                    2'b01: begin
                        if (page_q == PageLast) begin
                            page_d = 3'd0;
                            col_d  = (col_q == ColLast) ? 7'd0 : col_q + 7'd1;
                        end else begin
                            page_d = page_q + 3'd1;
                        end
                    end
                    default: col_d = (col_q == ColLast) ? 7'd0 : col_q + 7'd1;
                endcase
            end else if (state_q == DecArg) begin
                case (arg_op_q)
                    OpContrast: contrast_d = byte_q;
                    OpMode:     mode_d     = byte_q[1:0];
                    default:    ;
                endcase
                state_d  = DecCmd;
                arg_op_d = OpNone;
            end else begin
                case (byte_q) inside
                    8'hAE: disp_on_d = 1'b0;
                    8'hAF: disp_on_d = 1'b1;
                    8'h81: begin
                        state_d  = DecArg;
                        arg_op_d = OpContrast;
                    end
                    8'h20: begin
                        state_d  = DecArg;
                        arg_op_d = OpMode;
                    end
                    8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: begin
                        state_d  = DecArg;
                        arg_op_d = OpNone;
                    end
                    [8'hB0:8'hB7]: page_d = byte_q[2:0];
                    [8'h00:8'h0F]: col_d[3:0] = byte_q[3:0];
                    [8'h10:8'h17]: col_d[6:4] = byte_q[2:0];
                    default: ;
                endcase
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge i_clk) begin
        if (srst) begin
            state_q    <= DecCmd;
            arg_op_q   <= OpNone;
            disp_on_q  <= 1'b0;
            contrast_q <= 8'h7F;
            mode_q     <= 2'b10;
            col_q      <= 7'd0;
            page_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            arg_op_q   <= arg_op_d;
            disp_on_q  <= disp_on_d;
            contrast_q <= contrast_d;
            mode_q     <= mode_d;
            col_q      <= col_d;
            page_q     <= page_d;
        end
    end

`ifdef LCD_RX_CMD_COUNT_EN
    logic [15:0] cmd_count_q;

    // Saturating count of every command-phase byte, arguments included.
    always_ff @(posedge i_clk) begin
        if (srst) begin
            cmd_count_q <= 16'h0000;
        end else if (byte_valid_q && !byte_dc_q && cmd_count_q != 16'hFFFF) begin
            cmd_count_q <= cmd_count_q + 16'd1;
        end
    end

    assign bus.o_cmd_count = cmd_count_q;
`endif

    assign bus.o_byte_valid = byte_valid_q;
    assign bus.o_byte       = byte_q;
    assign bus.o_byte_dc    = byte_dc_q;
    assign bus.o_frame_err  = frame_err_q;
    // Pixel write carries the pre-increment address.
    assign bus.o_pix_we     = byte_valid_q & byte_dc_q;
    assign bus.o_pix_col    = col_q;
    assign bus.o_pix_page   = page_q;
    assign bus.o_pix_data   = byte_q;
    assign bus.o_disp_on    = disp_on_q;
    assign bus.o_contrast   = contrast_q;
    assign bus.o_addr_mode  = mode_q;
endmodule
